icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss handler for the L1 instruction cache. Detects a fetch miss, fetches the 8-byte
//  line from memory as two 32-bit words, then drives the cache write port for one cycle.
//  Stalls fetch until the refilled line hits. Sits between fetch/L1 I-cache and memory.
// PARAMETERS
//  ADDR_WIDTH      32   fetch/memory address width
//  INDEX_BITS      4    cache index width (16 lines); tag = ADDR_WIDTH-INDEX_BITS-3 = 25
//  TIMEOUT_CYCLES  256  watchdog limit per memory wait (ICACHE_REFILL_TIMEOUT_EN only)
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  fetchAddress   in   32  current PC presented to the cache
//  fetchValid     in   1   fetch is requesting fetchAddress this cycle
//  cacheHit       in   1   hit result from the L1 I-cache for fetchAddress
//  flush          in   1   pipeline redirect; abandon any refill in progress
//  fetchStall     out  1   hold PC; asserted on miss and for the whole refill
//  memReqValid    out  1   memory read request valid
//  memReqReady    in   1   memory accepts request when valid & ready
//  memReqAddress  out  32  word address of the read (lineBase or lineBase+4)
//  memRespValid   in   1   read data valid (in order, one outstanding)
//  memRespData    in   32  read data
//  writeCache     out  1   one-cycle cache fill strobe
//  writeIndex     out  4   fill index = lineBase[6:3]
//  writeTag       out  25  fill tag = lineBase[31:7]
//  writeData      out  64  {hiWord, loWord}
//  refillError    out  1   sticky watchdog error (0 when macro is off)
// BEHAVIOUR
//  States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, FILL, DRAIN.
//  Reset: state=IDLE, memReqValid=0, writeCache=0, writeIndex/Tag/Data=0, refillError=0.
//  IDLE: fetchValid & ~cacheHit & ~flush -> latch lineBase = {fetchAddress[31:3],3'b0}, go REQ_LO.
//  REQ_LO/REQ_HI: memReqValid=1, addr lineBase / lineBase+4; held stable until memReqReady.
//    Handshake -> WAIT_LO / WAIT_HI.
//  WAIT_LO: memRespValid -> capture loWord, go REQ_HI. WAIT_HI: capture hiWord, go FILL.
//  FILL: writeCache=1 exactly one cycle with index/tag/data, then IDLE. Cache is written on
//    that edge; the next IDLE cycle sees a hit. Miss-to-hit latency = 5 cycles + memory waits.
//  fetchStall = (state!=IDLE) | (fetchValid & ~cacheHit); combinational.
//  fetchAddress changes during a refill are ignored; lineBase is latched once.
//  memRespValid outside WAIT_LO/WAIT_HI/DRAIN is ignored.
//  flush (highest priority over normal transitions):
//    IDLE: no miss is started. REQ_x with ~memReqReady: go IDLE, no request issued.
//    REQ_x with memReqReady (accepted this edge): go DRAIN.
//    WAIT_x with memRespValid same cycle: response consumed, go IDLE.
//    WAIT_x without response: go DRAIN.
//    FILL: write still completes (data valid), go IDLE.
//  DRAIN: fetchStall=1, memReqValid=0; on memRespValid discard data, go IDLE. No cache write.
//  Only one memory request is outstanding at any time.
// CONFIGURATION
//  ICACHE_REFILL_TIMEOUT_EN defined: a watchdog counts cycles in WAIT_x/DRAIN and clears on
//    state change. At TIMEOUT_CYCLES it sets refillError (sticky until reset), goes IDLE,
//    and writes nothing. A late response arriving in IDLE is ignored.
//  Not defined: no counter, refillError tied 0, waits are unbounded.
// STRUCTURE
//  icache_pkg: refill_state_t enum, LINE_BYTES=8, OFFSET_BITS=3, INDEX_BITS, TAG_BITS.
//    The L1 cache shares the same geometry constants.
//  Sub-module refill_watchdog (counter + compare), instantiated only under the macro.
// TESTING
//  Miss at 0x0000_0084, memory responds 0xAAAA_0001 then 0xBBBB_0002 with 0 wait ->
//    reqs 0x80 then 0x84; writeIndex=0, writeTag=0x1, writeData=0xBBBB0002_AAAA0001, 1 pulse.
//  memReqReady low for 3 cycles in REQ_LO -> memReqValid/addr stable for 4 cycles; one request.
//  flush in WAIT_LO with no response, response arrives 2 cycles later -> DRAIN absorbs it,
//    writeCache never asserts, fetchStall drops the cycle after return to IDLE.
//  flush in REQ_HI with memReqReady=0 -> IDLE next cycle, no second request seen.
//  Reset asserted in WAIT_HI -> IDLE; all outputs are 0 next cycle; a later stray response
//    does not write the cache.
//  Macro on, TIMEOUT_CYCLES=8, no response -> refillError=1 after 8 wait cycles, state IDLE,
//    no write.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Geometry constants and refill FSM state type shared by the L1 instruction
// cache and its refill controller.
//   LINE_BYTES   : bytes per cache line (two 32-bit words)
//   WORD_BYTES   : bytes per memory read
//   OFFSET_BITS  : byte-offset bits inside a line
//   INDEX_BITS   : cache index width (16 lines)
//   TAG_BITS     : tag width for a 32-bit address
//   refill_state_t : refill controller states
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam int LINE_BYTES  = 8;
   localparam int WORD_BYTES  = 4;
   localparam int OFFSET_BITS = 3;
   localparam int INDEX_BITS  = 4;
   localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ_LO  = 3'd1,
      WAIT_LO = 3'd2,
      REQ_HI  = 3'd3,
      WAIT_HI = 3'd4,
      FILL    = 3'd5,
      DRAIN   = 3'd6
   } refill_state_t;

   // States in which the controller is waiting on the memory response path.
   function automatic logic is_wait_state(input refill_state_t s);
      return (s == WAIT_LO) || (s == WAIT_HI) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/icache_refill_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// refill_watchdog
// Cycle counter that bounds how long the refill controller may sit waiting for
// a memory response. Counts while 'active', restarts on every state change of
// the controller, and flags 'expired' on the LIMIT-th consecutive wait cycle.
// Ports:
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   active   in  controller is in a wait state this cycle
//   restart  in  controller changes state on the coming edge
//   expired  out this is the LIMIT-th wait cycle in the current state
// -----------------------------------------------------------------------------
module refill_watchdog #(
   parameter int LIMIT = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic restart,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, exactly like the hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (restart || !active) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // count holds the number of earlier wait cycles, so LIMIT-1 marks the
   // LIMIT-th cycle; the controller leaves on that edge.
   assign expired = active && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Miss handler for the L1 instruction cache. On a fetch miss it latches the
// line base, reads the 8-byte line from memory as two 32-bit words (one
// request outstanding at a time), then strobes the cache write port for one
// cycle. Fetch is stalled from the miss until the refilled line hits.
// A flush abandons the refill; an already accepted request is drained so its
// response never reaches the cache.
//
// Optional feature: define ICACHE_REFILL_TIMEOUT_EN to add a watchdog that
// bounds every memory wait to TIMEOUT_CYCLES and sets a sticky refillError.
// Without it waits are unbounded and refillError is tied low.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   fetchAddress    PC presented to the cache
//   fetchValid      fetch request this cycle
//   cacheHit        L1 hit result for fetchAddress
//   flush           pipeline redirect, abandons any refill
//   fetchStall      hold PC (combinational)
//   memReqValid/Ready/Address   memory read request channel
//   memRespValid/Data           memory read response channel
//   writeCache      one-cycle fill strobe
//   writeIndex/Tag/Data         fill index, tag and {hiWord, loWord}
//   refillError     sticky watchdog error
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int INDEX_BITS     = icache_pkg::INDEX_BITS,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                                                    clk,
   input  logic                                                    reset,
   input  logic [ADDR_WIDTH-1:0]                                   fetchAddress,
   input  logic                                                    fetchValid,
   input  logic                                                    cacheHit,
   input  logic                                                    flush,
   output logic                                                    fetchStall,
   output logic                                                    memReqValid,
   input  logic                                                    memReqReady,
   output logic [ADDR_WIDTH-1:0]                                   memReqAddress,
   input  logic                                                    memRespValid,
   input  logic [31:0]                                             memRespData,
   output logic                                                    writeCache,
   output logic [INDEX_BITS-1:0]                                   writeIndex,
   output logic [ADDR_WIDTH-INDEX_BITS-icache_pkg::OFFSET_BITS-1:0] writeTag,
   output logic [63:0]                                             writeData,
   output logic                                                    refillError
);

   import icache_pkg::*;

   localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] HI_OFFSET   = ADDR_WIDTH'(WORD_BYTES);

   refill_state_t         state;
   refill_state_t         state_next;
   logic [ADDR_WIDTH-1:0] line_base;
   logic [31:0]           lo_word;
   logic [31:0]           hi_word;
   logic                  miss;
   logic                  latch_base;
   logic                  capture_lo;
   logic                  capture_hi;
   logic                  timeout;

   assign miss       = fetchValid & ~cacheHit;
   assign fetchStall = (state != IDLE) | miss;

   // ---------------------------------------------------------------------------
   // Next-state logic. flush outranks every normal transition; a response in
   // the same cycle as the flush still counts as consumed, so the channel is
   // left idle. A response beats the watchdog in the same cycle.
   // ---------------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      latch_base = 1'b0;
      capture_lo = 1'b0;
      capture_hi = 1'b0;
      unique case (state)
         IDLE: begin
            if (miss && !flush) begin
               latch_base = 1'b1;
               state_next = REQ_LO;
            end
         end
         REQ_LO: begin
            if (flush)            state_next = memReqReady ? DRAIN : IDLE;
            else if (memReqReady) state_next = WAIT_LO;
         end
         WAIT_LO: begin
            if (flush) begin
               state_next = memRespValid ? IDLE : DRAIN;
            end else if (memRespValid) begin
               capture_lo = 1'b1;
               state_next = REQ_HI;
            end else if (timeout) begin
               state_next = IDLE;
            end
         end
         REQ_HI: begin
            if (flush)            state_next = memReqReady ? DRAIN : IDLE;
            else if (memReqReady) state_next = WAIT_HI;
         end
         WAIT_HI: begin
            if (flush) begin
               state_next = memRespValid ? IDLE : DRAIN;
            end else if (memRespValid) begin
               capture_hi = 1'b1;
               state_next = FILL;
            end else if (timeout) begin
               state_next = IDLE;
            end
         end
         // The line is complete, so the write goes out even if flush is high.
         FILL: state_next = IDLE;
         // Only the response of the abandoned request is awaited here.
         DRAIN: begin
            if (memRespValid || timeout) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs decoded from state. Address and fill fields are zero whenever
   // their strobe is low so idle buses stay quiet.
   // ---------------------------------------------------------------------------
   always_comb begin
      memReqValid   = 1'b0;
      memReqAddress = '0;
      writeCache    = 1'b0;
      writeIndex    = '0;
      writeTag      = '0;
      writeData     = '0;
      case (state)
         REQ_LO: begin
            memReqValid   = 1'b1;
            memReqAddress = line_base;
         end
         REQ_HI: begin
            memReqValid   = 1'b1;
            memReqAddress = line_base + HI_OFFSET;
         end
         FILL: begin
            writeCache = 1'b1;
            writeIndex = line_base[OFFSET_BITS +: INDEX_BITS];
            writeTag   = line_base[ADDR_WIDTH-1 -: TAG_W];
            writeData  = {hi_word, lo_word};
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers. lineBase is latched once per miss, so PC
   // changes during the refill cannot disturb the request addresses.
   // ---------------------------------------------------------------------------
   // NOTE: the line-base and data words are reset as well; they are only a few
   // flops and this keeps the fill fields at a known value straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         line_base <= '0;
         lo_word   <= '0;
         hi_word   <= '0;
      end else begin
         state <= state_next;
         if (latch_base) line_base <= fetchAddress & ~OFFSET_MASK;
         if (capture_lo) lo_word   <= memRespData;
         if (capture_hi) hi_word   <= memRespData;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional wait watchdog.
   // ---------------------------------------------------------------------------
`ifdef ICACHE_REFILL_TIMEOUT_EN
   logic error_q;
   logic timeout_taken;

   refill_watchdog #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .active  (is_wait_state(state)),
      .restart (state_next != state),
      .expired (timeout)
   );

   // The error is recorded only when the watchdog itself ended the wait, not
   // when a response or a flush arrived in the same cycle.
   assign timeout_taken = timeout & ~memRespValid & (state_next == IDLE);

   always_ff @(posedge clk) begin
      if (reset)              error_q <= 1'b0;
      else if (timeout_taken) error_q <= 1'b1;
   end

   assign refillError = error_q;
`else
   assign timeout     = 1'b0;
   assign refillError = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
// Self-checking bench for icache_refill_ctrl. Directed scenarios followed by
// randomised refills (random line, data, memory wait states and flush point).
// Expected values come from a transaction-level view of a refill: the line
// base, the two word addresses, the index/tag split of the line base and the
// outcome of a flush at a given phase.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

   import icache_pkg::*;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset;
   logic [31:0]         fetchAddress;
   logic                fetchValid;
   logic                cacheHit;
   logic                flush;
   logic                fetchStall;
   logic                memReqValid;
   logic                memReqReady;
   logic [31:0]         memReqAddress;
   logic                memRespValid;
   logic [31:0]         memRespData;
   logic                writeCache;
   logic [3:0]          writeIndex;
   logic [TAG_BITS-1:0] writeTag;
   logic [63:0]         writeData;
   logic                refillError;

   int vectors     = 0;
   int miscompares = 0;

   icache_refill_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .fetchAddress  (fetchAddress),
      .fetchValid    (fetchValid),
      .cacheHit      (cacheHit),
      .flush         (flush),
      .fetchStall    (fetchStall),
      .memReqValid   (memReqValid),
      .memReqReady   (memReqReady),
      .memReqAddress (memReqAddress),
      .memRespValid  (memRespValid),
      .memRespData   (memRespData),
      .writeCache    (writeCache),
      .writeIndex    (writeIndex),
      .writeTag      (writeTag),
      .writeData     (writeData),
      .refillError   (refillError)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL sim_timeout: observed no end of test, expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle's inputs just after the clock edge, then let them settle.
   task automatic drive(input logic fv, input logic [31:0] fa, input logic hit,
                        input logic fl, input logic rdy, input logic rv,
                        input logic [31:0] rd);
      fetchValid   = fv;
      fetchAddress = fa;
      cacheHit     = hit;
      flush        = fl;
      memReqReady  = rdy;
      memRespValid = rv;
      memRespData  = rd;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_stall"}, fetchStall, 0);
      check({tag, "_req"},   memReqValid, 0);
      check({tag, "_write"}, writeCache, 0);
   endtask

   // One miss transaction. d0..d3: extra cycles spent in REQ_LO, WAIT_LO,
   // REQ_HI, WAIT_HI before the handshake. fph: 0 = no flush, 1..4 = flush on
   // the last cycle of that phase, 5 = flush during the fill. fhs: the
   // handshake/response coincides with the flush. dlat: drain cycles before the
   // abandoned response returns.
   task automatic run_miss(input logic [31:0] a, input logic [31:0] lo,
                           input logic [31:0] hi, input int d0, input int d1,
                           input int d2, input int d3, input int fph,
                           input logic fhs, input int dlat);
      int          delay [4];
      logic [31:0] word  [2];
      logic [31:0] base;
      logic [31:0] addr_exp;
      bit          is_req;
      bit          last;
      bit          fl;
      bit          hs;
      bit          drain;
      delay = '{d0, d1, d2, d3};
      word  = '{lo, hi};
      base  = (a / LINE_BYTES) * LINE_BYTES;

      drive(1'b1, a, 1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom);
      check("miss_stall", fetchStall, 1);
      check("miss_noreq", memReqValid, 0);
      next_cycle();

      for (int ph = 0; ph < 4; ph++) begin
         is_req   = (ph % 2 == 0);
         addr_exp = base + 32'((ph / 2) * WORD_BYTES);
         for (int c = 0; c <= delay[ph]; c++) begin
            last = (c == delay[ph]);
            fl   = last && (fph == ph + 1);
            hs   = last && (!fl || fhs);
            if (is_req) drive(1'b1, $urandom, 1'b0, fl, hs, 1'($urandom), $urandom);
            else        drive(1'b1, $urandom, 1'b0, fl, 1'($urandom), hs,
                              hs ? word[ph / 2] : $urandom);
            check(is_req ? "req_valid" : "wait_noreq", memReqValid, is_req);
            if (is_req) check("req_addr", memReqAddress, addr_exp);
            check("busy_stall", fetchStall, 1);
            check("busy_nowrite", writeCache, 0);
            next_cycle();
         end
         if (fph == ph + 1) begin
            drain = is_req ? fhs : !fhs;
            if (drain) begin
               for (int d = 0; d <= dlat; d++) begin
                  drive(1'b1, $urandom, 1'b0, 1'b0, 1'($urandom), d == dlat, $urandom);
                  check("drain_noreq", memReqValid, 0);
                  check("drain_stall", fetchStall, 1);
                  check("drain_nowrite", writeCache, 0);
                  next_cycle();
               end
            end
            drive(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check_quiet("flushed_idle");
            next_cycle();
            return;
         end
      end

      drive(1'b1, a, 1'b0, fph == 5, 1'($urandom), 1'($urandom), $urandom);
      check("fill_strobe", writeCache, 1);
      check("fill_index", writeIndex, (base / LINE_BYTES) % 16);
      check("fill_tag", writeTag, base / 128);
      check("fill_data", writeData, {hi, lo});
      check("fill_stall", fetchStall, 1);
      check("fill_noreq", memReqValid, 0);
      next_cycle();

      if (fph == 5) drive(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      else          drive(1'b1, a, 1'b1, 1'b0, 1'($urandom), 1'($urandom), $urandom);
      check_quiet("after_fill");
      next_cycle();
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] base;
      int          fph;

      // Power-on reset.
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) next_cycle();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_quiet("reset");
      check("reset_addr", memReqAddress, 0);
      check("reset_index", writeIndex, 0);
      check("reset_tag", writeTag, 0);
      check("reset_data", writeData, 0);
      check("reset_error", refillError, 0);

      // fetchStall is combinational on a miss even in IDLE; hits never stall.
      drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("hit_nostall", fetchStall, 0);
      next_cycle();

      // Miss at 0x84 with zero-wait memory.
      run_miss(32'h0000_0084, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0, 0, 0, 0, 1'b0, 0);

      // Request held for 3 cycles: address/valid stable for 4 cycles.
      run_miss(32'h0000_1230, 32'h1111_2222, 32'h3333_4444, 3, 1, 0, 2, 0, 1'b0, 0);

      // Flush in WAIT_LO without response; response 2 cycles later.
      run_miss(32'h0000_0F08, 32'h0, 32'h0, 0, 0, 0, 0, 2, 1'b0, 1);

      // Flush in REQ_HI with ready low: no second request ever appears.
      run_miss(32'h8000_0010, 32'hCAFE_0000, 32'h0, 0, 0, 1, 0, 3, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, $urandom, 1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom);
         check("no_hi_req", memReqValid, 0);
         next_cycle();
      end

      // Flush in IDLE on a miss: no refill starts.
      drive(1'b1, 32'h0000_2000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("idle_flush_stall", fetchStall, 1);
      next_cycle();
      drive(1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_quiet("idle_flush");
      next_cycle();

      // Reset asserted in WAIT_HI, then a stray response arrives.
      a    = 32'h1234_5678;
      base = (a / LINE_BYTES) * LINE_BYTES;
      drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      next_cycle();
      drive(1'b1, a, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("rst_req_lo", memReqAddress, base);
      next_cycle();
      drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
      next_cycle();
      drive(1'b1, a, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("rst_req_hi", memReqAddress, base + WORD_BYTES);
      next_cycle();
      reset = 1'b1;
      drive(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("rst_in_wait_hi", memReqValid, 0);
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_quiet("post_reset");
      check("post_reset_addr", memReqAddress, 0);
      check("post_reset_index", writeIndex, 0);
      check("post_reset_tag", writeTag, 0);
      check("post_reset_data", writeData, 0);
      check("post_reset_error", refillError, 0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_7777);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         check_quiet("stray_resp");
         next_cycle();
      end

      // Watchdog: no response for 8 wait cycles ends the refill with an error.
      if (TO_EN) begin
         drive(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         next_cycle();
         drive(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         next_cycle();
         for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("to_waiting", fetchStall, 1);
            check("to_no_error_yet", refillError, 0);
            next_cycle();
         end
         drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
         check_quiet("to_idle");
         check("to_error", refillError, 1);
         next_cycle();
         drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         check_quiet("to_late_resp");
         check("to_error_sticky", refillError, 1);
         next_cycle();
      end

      // Randomised refills with random wait states and flush points.
      for (int n = 0; n < 40; n++) begin
         fph = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 5));
         run_miss($urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  fph, 1'($urandom), $urandom_range(0, 2));
      end
      check("final_error", refillError, TO_EN);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
